// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - memory-op codes, FSM states and lane helpers for mem_access
package mem_access_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int MEM_OP_BUS = 4;
    typedef logic [MEM_OP_BUS-1:0] mem_op_t;

    localparam mem_op_t MEM_OP_NONE = 4'd0;
    localparam mem_op_t MEM_OP_LB   = 4'd1;
    localparam mem_op_t MEM_OP_LBU  = 4'd2;
    localparam mem_op_t MEM_OP_LH   = 4'd3;
    localparam mem_op_t MEM_OP_LHU  = 4'd4;
    localparam mem_op_t MEM_OP_LW   = 4'd5;
    localparam mem_op_t MEM_OP_SB   = 4'd6;
    localparam mem_op_t MEM_OP_SH   = 4'd7;
    localparam mem_op_t MEM_OP_SW   = 4'd8;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_REQ  = 1'b1
    } state_e;

    // Lane mask for lane 0; zero marks a non-memory op (including codes 9-15).
    function automatic logic [3:0] op_base_mask(input mem_op_t op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 4'b0001;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 4'b0011;
            MEM_OP_LW, MEM_OP_SW:             return 4'b1111;
            default:                          return 4'b0000;
        endcase
    endfunction

    function automatic logic op_is_load(input mem_op_t op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
    endfunction

    function automatic logic op_aligned(input mem_op_t op, input logic [1:0] lane);
        case (op_base_mask(op))
            4'b0011: return !lane[0];
            4'b1111: return lane == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed lane of a read word and sign/zero extends it
module load_extend
    import mem_access_pkg::*;
(
    input  mem_op_t     mem_op,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        data = rdata;
        case (mem_op)
            MEM_OP_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_OP_LBU: data = {24'h0, shifted[7:0]};
            MEM_OP_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_OP_LHU: data = {16'h0, shifted[15:0]};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: req/ack data-memory access and registered writeback
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [MEM_OP_BUS-1:0]     in_mem_op,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    input  logic                      input_write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] input_write_addr,
    input  logic [DATA_WIDTH-1:0]     input_write_data,
    input  logic                      flush,
    output logic                      stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [3:0]                mem_byte_sel,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      wb_valid,
    output logic                      write_enable,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      exc_misaligned
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("mem_access supports DATA_WIDTH == 32 only");
    end

    state_e                    state;
    mem_op_t                   op_r;
    logic [1:0]                lane_r;
    logic                      we_r;
    logic [REG_ADDR_WIDTH-1:0] waddr_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic                      dropped;

    logic [3:0]            base_mask;
    logic [1:0]            lane;
    logic                  is_mem;
    logic                  aligned;
    logic                  accept;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] store_rep;
    logic [DATA_WIDTH-1:0] load_data;

    assign base_mask  = op_base_mask(in_mem_op);
    assign lane       = in_addr[1:0];
    assign is_mem     = |base_mask;
    assign aligned    = op_aligned(in_mem_op, lane);
    assign accept     = (state == STATE_IDLE) && in_valid && is_mem && aligned;
    assign misaligned = in_valid && is_mem && !aligned;
    assign stall      = (state == STATE_REQ) || accept;

    always_comb begin
        store_rep = in_store_data;
        case (base_mask)
            4'b0001: store_rep = {4{in_store_data[7:0]}};
            4'b0011: store_rep = {2{in_store_data[15:0]}};
            default: store_rep = in_store_data;
        endcase
    end

    load_extend u_load_extend (
        .mem_op (op_r),
        .lane   (lane_r),
        .rdata  (mem_rdata),
        .data   (load_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= STATE_IDLE;
            op_r           <= MEM_OP_NONE;
            lane_r         <= '0;
            we_r           <= DISABLE;
            waddr_r        <= '0;
            wdata_r        <= '0;
            dropped        <= DISABLE;
            mem_req        <= DISABLE;
            mem_we         <= DISABLE;
            mem_addr       <= '0;
            mem_byte_sel   <= '0;
            mem_wdata      <= '0;
            wb_valid       <= DISABLE;
            write_enable   <= DISABLE;
            write_addr     <= '0;
            write_data     <= '0;
            exc_misaligned <= DISABLE;
        end else begin
            case (state)
                STATE_IDLE: begin
                    wb_valid       <= DISABLE;
                    exc_misaligned <= DISABLE;
                    if (accept) begin
                        state        <= STATE_REQ;
                        mem_req      <= ENABLE;
                        mem_we       <= op_is_store(in_mem_op);
                        mem_addr     <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_byte_sel <= base_mask << lane;
                        mem_wdata    <= store_rep;
                        op_r         <= in_mem_op;
                        lane_r       <= lane;
                        we_r         <= input_write_enable;
                        waddr_r      <= input_write_addr;
                        wdata_r      <= input_write_data;
                        dropped      <= flush;
                    end else if (in_valid) begin
                        // Misaligned accesses retire here too, with the write suppressed.
                        wb_valid       <= !flush;
                        exc_misaligned <= misaligned && !flush;
                        write_enable   <= input_write_enable && !misaligned;
                        write_addr     <= input_write_addr;
                        write_data     <= input_write_data;
                    end
                end
                STATE_REQ: begin
                    if (mem_ack) begin
                        state        <= STATE_IDLE;
                        mem_req      <= DISABLE;
                        wb_valid     <= !(dropped || flush);
                        write_enable <= we_r && op_is_load(op_r);
                        write_addr   <= waddr_r;
                        write_data   <= op_is_load(op_r) ? load_data : wdata_r;
                        dropped      <= DISABLE;
                    end else begin
                        dropped <= dropped || flush;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access
module tb_mem_access;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_mem_op;
    logic [31:0] in_addr;
    logic [31:0] in_store_data;
    logic        input_write_enable;
    logic [4:0]  input_write_addr;
    logic [31:0] input_write_data;
    logic        flush;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_sel;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        exc_misaligned;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] mem [0:1023];

    mem_access dut (
        .clock              (clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_mem_op          (in_mem_op),
        .in_addr            (in_addr),
        .in_store_data      (in_store_data),
        .input_write_enable (input_write_enable),
        .input_write_addr   (input_write_addr),
        .input_write_data   (input_write_data),
        .flush              (flush),
        .stall              (stall),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_byte_sel       (mem_byte_sel),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .wb_valid           (wb_valid),
        .write_enable       (write_enable),
        .write_addr         (write_addr),
        .write_data         (write_data),
        .exc_misaligned     (exc_misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    function automatic int op_size(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 1;
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2;
        if (op == 4'd5 || op == 4'd8) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (addr % 4));
        case (op)
            4'd1: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
            4'd2: v = v & 32'hFF;
            4'd3: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
            4'd4: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                          input int waits, input bit fl);
        int          size;
        int          lane;
        bit          ld;
        bit          st;
        bit          accepted;
        logic [31:0] word;
        logic [31:0] exp_wdata;
        logic [31:0] exp_sel;
        ld       = (op >= 4'd1) && (op <= 4'd5);
        st       = (op >= 4'd6) && (op <= 4'd8);
        size     = op_size(op);
        lane     = int'(addr % 4);
        accepted = (ld || st) && ((addr % size) == 0);

        in_valid           = 1'b1;
        in_mem_op          = op;
        in_addr            = addr;
        in_store_data      = sdata;
        input_write_enable = wen;
        input_write_addr   = waddr;
        input_write_data   = wdata;
        flush              = fl && !accepted;
        @(negedge clock);
        chk("wb_pulse_idle", 32'(wb_valid), 32'd0);
        chk("stall_issue", 32'(stall), 32'(accepted));

        if (!accepted) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
            flush    = 1'b0;
            @(negedge clock);
            chk("pt_wb_valid", 32'(wb_valid), 32'(!fl));
            chk("pt_exc", 32'(exc_misaligned), 32'(!fl && (ld || st)));
            chk("pt_stall", 32'(stall), 32'd0);
            chk("pt_mem_req", 32'(mem_req), 32'd0);
            if (!fl) begin
                chk("pt_write_enable", 32'(write_enable), (ld || st) ? 32'd0 : 32'(wen));
                chk("pt_write_addr", 32'(write_addr), 32'(waddr));
                chk("pt_write_data", write_data, wdata);
            end
        end else begin
            word      = mem[widx(addr)];
            exp_sel   = ((32'd1 << size) - 32'd1) << lane;
            exp_wdata = (size == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                        (size == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
            for (int k = 0; k <= waits; k++) begin
                @(posedge clock); #1;
                flush     = fl && (k == 0);
                mem_ack   = (k == waits);
                mem_rdata = (k == waits) ? word : $urandom;
                @(negedge clock);
                chk("req_mem_req", 32'(mem_req), 32'd1);
                chk("req_stall", 32'(stall), 32'd1);
                chk("req_addr", mem_addr, addr & ~32'd3);
                chk("req_we", 32'(mem_we), 32'(st));
                chk("req_byte_sel", 32'(mem_byte_sel), exp_sel);
                chk("req_wb_valid", 32'(wb_valid), 32'd0);
                if (st) chk("req_wdata", mem_wdata, exp_wdata);
            end
            @(posedge clock); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            in_valid  = 1'b0;
            flush     = 1'b0;
            if (st) begin
                for (int i = 0; i < size; i++) begin
                    word = (word & ~(32'hFF << (8 * (lane + i))))
                         | (((sdata >> (8 * i)) & 32'hFF) << (8 * (lane + i)));
                end
                mem[widx(addr)] = word;
            end
            @(negedge clock);
            chk("done_wb_valid", 32'(wb_valid), 32'(!fl));
            chk("done_mem_req", 32'(mem_req), 32'd0);
            chk("done_stall", 32'(stall), 32'd0);
            chk("done_exc", 32'(exc_misaligned), 32'd0);
            if (!fl) begin
                chk("done_write_enable", 32'(write_enable), ld ? 32'(wen) : 32'd0);
                if (ld) begin
                    chk("done_write_addr", 32'(write_addr), 32'(waddr));
                    chk("done_write_data", write_data, ref_load(op, addr, mem[widx(addr)]));
                end
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr;
        int          rwaits;
        bit          rfl;

        reset              = 1'b1;
        in_valid           = 1'b0;
        in_mem_op          = 4'd0;
        in_addr            = 32'd0;
        in_store_data      = 32'd0;
        input_write_enable = 1'b0;
        input_write_addr   = 5'd0;
        input_write_data   = 32'd0;
        flush              = 1'b0;
        mem_ack            = 1'b0;
        mem_rdata          = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_write_enable", 32'(write_enable), 32'd0);
        chk("rst_write_addr", 32'(write_addr), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_exc", 32'(exc_misaligned), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_byte_sel", 32'(mem_byte_sel), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_op(4'd0, 32'h0, 32'h0, 1'b1, 5'd3, 32'hDEAD_BEEF, 0, 1'b0);
        mem[widx(32'h1003)] = 32'h80FF_0000;
        run_op(4'd1, 32'h1003, 32'h0, 1'b1, 5'd7, 32'h0, 2, 1'b0);
        mem[widx(32'h2002)] = 32'hBEEF_1234;
        run_op(4'd4, 32'h2002, 32'h0, 1'b1, 5'd9, 32'h0, 1, 1'b0);
        run_op(4'd5, 32'h2004, 32'h0, 1'b1, 5'd10, 32'h0, 0, 1'b0);
        run_op(4'd6, 32'h10, 32'h1234_56AB, 1'b1, 5'd11, 32'h5555_0000, 0, 1'b0);
        run_op(4'd1, 32'h10, 32'h0, 1'b1, 5'd12, 32'h0, 0, 1'b0);
        run_op(4'd5, 32'h4001, 32'h0, 1'b1, 5'd13, 32'h0102_0304, 0, 1'b0);
        run_op(4'd3, 32'h4003, 32'h0, 1'b1, 5'd14, 32'h0, 0, 1'b0);
        run_op(4'd7, 32'h22, 32'hCAFE_F00D, 1'b1, 5'd15, 32'h0, 3, 1'b0);
        run_op(4'd5, 32'h100, 32'h0, 1'b1, 5'd16, 32'h0, 2, 1'b1);
        run_op(4'd0, 32'h0, 32'h0, 1'b1, 5'd17, 32'h1111_2222, 0, 1'b1);
        run_op(4'd12, 32'h55, 32'h0, 1'b1, 5'd18, 32'h3333_4444, 0, 1'b0);

        // Reset during an outstanding request must drop mem_req without a clock edge.
        in_valid           = 1'b1;
        in_mem_op          = 4'd5;
        in_addr            = 32'h40;
        input_write_enable = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("rstreq_mem_req_before", 32'(mem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstreq_mem_req_after", 32'(mem_req), 32'd0);
        chk("rstreq_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_op(4'd0, 32'h0, 32'h0, 1'b1, 5'd19, 32'h0BAD_CAFE, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            rop    = 4'($urandom_range(0, 15));
            raddr  = {20'h0, 12'($urandom)};
            rwaits = $urandom_range(0, 3);
            rfl    = (rop < 4'd6 || rop > 4'd8) && ($urandom_range(0, 5) == 0);
            run_op(rop, raddr, $urandom, 1'($urandom), 5'($urandom), $urandom, rwaits, rfl);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
